// File: rtl/pe_load_scheduler.sv
// Row-load sequencer between the PE depacketizer and the convolution datapath:
// routes filter/ifmap rows into their buffers and launches one conv per full window.
module pe_load_scheduler #(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned NUM_ROWS     = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_ifmapb_filter,
  input  logic [2:0]                in_filter_row,
  input  logic                      in_timestep,
  input  logic [5*FILTER_WIDTH-1:0] in_data,
  output logic                      filt_wr_en,
  output logic                      ifm_wr_en,
  output logic [2:0]                wr_row,
  output logic [5*FILTER_WIDTH-1:0] wr_data,
  output logic                      conv_start,
  output logic                      conv_timestep,
  input  logic                      conv_done,
  output logic                      filter_loaded,
  output logic [CNT_W-1:0]          conv_count,
  output logic                      err_row,
  output logic                      err_ts
);

  localparam int unsigned DW = 5 * FILTER_WIDTH;
  localparam logic [3:0] ROW_LIM = 4'(NUM_ROWS);

  typedef enum logic [1:0] {LOAD, START, BUSY} state_t;

  state_t                state_q, state_d;
  logic [NUM_ROWS-1:0]   filt_mask_q, filt_mask_d;
  logic [NUM_ROWS-1:0]   ifm_mask_q, ifm_mask_d;
  logic                  win_ts_q, win_ts_d;
  logic [CNT_W-1:0]      conv_count_q, conv_count_d;
  logic                  err_row_q, err_row_d;
  logic                  err_ts_q, err_ts_d;
  logic                  filt_wr_en_q, filt_wr_en_d;
  logic                  ifm_wr_en_q, ifm_wr_en_d;
  logic [2:0]            wr_row_q, wr_row_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  conv_start_q, conv_start_d;
  logic                  conv_ts_q, conv_ts_d;
  logic                  xfer;
  logic                  row_ok;

  assign filter_loaded = &filt_mask_q;
  assign in_ready      = ~rst & (state_q == LOAD) & (in_ifmapb_filter | filter_loaded);
  assign xfer          = in_valid & in_ready;
  assign row_ok        = {1'b0, in_filter_row} < ROW_LIM;

  always_comb begin
    state_d      = state_q;
    filt_mask_d  = filt_mask_q;
    ifm_mask_d   = ifm_mask_q;
    win_ts_d     = win_ts_q;
    conv_count_d = conv_count_q;
    err_row_d    = err_row_q;
    err_ts_d     = err_ts_q;
    filt_wr_en_d = 1'b0;
    ifm_wr_en_d  = 1'b0;
    wr_row_d     = wr_row_q;
    wr_data_d    = wr_data_q;
    conv_start_d = 1'b0;
    conv_ts_d    = conv_ts_q;

    case (state_q)
      LOAD: begin
        if (xfer) begin
          if (!row_ok) begin
            err_row_d = 1'b1;
          end else if (in_ifmapb_filter) begin
            filt_mask_d[in_filter_row] = 1'b1;
            filt_wr_en_d = 1'b1;
            wr_row_d     = in_filter_row;
            wr_data_d    = in_data;
          end else if ((ifm_mask_q != '0) && (in_timestep != win_ts_q)) begin
            err_ts_d = 1'b1;
          end else begin
            if (ifm_mask_q == '0) win_ts_d = in_timestep;
            ifm_mask_d[in_filter_row] = 1'b1;
            ifm_wr_en_d = 1'b1;
            wr_row_d    = in_filter_row;
            wr_data_d   = in_data;
            if (&ifm_mask_d) state_d = START;
          end
        end
      end
      // START spans two cycles: the first lets the last row write land,
      // the second carries the registered launch pulse.
      START: begin
        if (!conv_start_q) begin
          conv_start_d = 1'b1;
          conv_ts_d    = win_ts_q;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (conv_done) begin
          state_d      = LOAD;
          ifm_mask_d   = '0;
          conv_count_d = conv_count_q + CNT_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      filt_mask_q  <= '0;
      ifm_mask_q   <= '0;
      win_ts_q     <= 1'b0;
      conv_count_q <= '0;
      err_row_q    <= 1'b0;
      err_ts_q     <= 1'b0;
      filt_wr_en_q <= 1'b0;
      ifm_wr_en_q  <= 1'b0;
      wr_row_q     <= '0;
      wr_data_q    <= '0;
      conv_start_q <= 1'b0;
      conv_ts_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_mask_q  <= filt_mask_d;
      ifm_mask_q   <= ifm_mask_d;
      win_ts_q     <= win_ts_d;
      conv_count_q <= conv_count_d;
      err_row_q    <= err_row_d;
      err_ts_q     <= err_ts_d;
      filt_wr_en_q <= filt_wr_en_d;
      ifm_wr_en_q  <= ifm_wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_data_q    <= wr_data_d;
      conv_start_q <= conv_start_d;
      conv_ts_q    <= conv_ts_d;
    end
  end

  assign filt_wr_en    = filt_wr_en_q;
  assign ifm_wr_en     = ifm_wr_en_q;
  assign wr_row        = wr_row_q;
  assign wr_data       = wr_data_q;
  assign conv_start    = conv_start_q;
  assign conv_timestep = conv_ts_q;
  assign conv_count    = conv_count_q;
  assign err_row       = err_row_q;
  assign err_ts        = err_ts_q;

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Bench for pe_load_scheduler: vector table of row packets, write/launch scoreboards,
// plus hand sequences for stall, busy hand-off and reset-in-busy.
module tb_pe_load_scheduler;

  localparam int unsigned FW = 8;
  localparam int unsigned DW = 5 * FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_ifmapb_filter = 1'b0;
  logic [2:0]    in_filter_row = '0;
  logic          in_timestep = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          filt_wr_en, ifm_wr_en;
  logic [2:0]    wr_row;
  logic [DW-1:0] wr_data;
  logic          conv_start, conv_timestep;
  logic          conv_done = 1'b0;
  logic          filter_loaded;
  logic [15:0]   conv_count;
  logic          err_row, err_ts;

  pe_load_scheduler #(.FILTER_WIDTH(FW), .NUM_ROWS(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ifmapb_filter(in_ifmapb_filter), .in_filter_row(in_filter_row),
    .in_timestep(in_timestep), .in_data(in_data),
    .filt_wr_en(filt_wr_en), .ifm_wr_en(ifm_wr_en),
    .wr_row(wr_row), .wr_data(wr_data),
    .conv_start(conv_start), .conv_timestep(conv_timestep),
    .conv_done(conv_done), .filter_loaded(filter_loaded),
    .conv_count(conv_count), .err_row(err_row), .err_ts(err_ts)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int n_launch = 0;

  typedef struct {
    logic          filt;
    logic [2:0]    row;
    logic          ts;
    logic [DW-1:0] data;
    logic          wr;
    logic          launch;
  } vec_t;

  typedef struct {
    logic          filt;
    logic [2:0]    row;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic        ts;
    int unsigned cyc;
  } ln_t;

  vec_t vecs[$];
  wr_t  wr_q[$];
  ln_t  ln_q[$];
  wr_t  we;
  ln_t  le;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every strobe and launch must match the next expected entry.
  always @(negedge clk) begin
    if (filt_wr_en || ifm_wr_en) begin
      n_cmp++;
      if (filt_wr_en && ifm_wr_en) begin
        n_bad++;
        $display("FAIL dual_strobe: got both strobes expected one (cycle %0d)", cyc);
      end else if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got filt=%0b row=%0d data=%0h expected none (cycle %0d)",
                 filt_wr_en, wr_row, wr_data, cyc);
      end else begin
        we = wr_q.pop_front();
        if (we.filt !== filt_wr_en || we.row !== wr_row || we.data !== wr_data) begin
          n_bad++;
          $display("FAIL write: got filt=%0b row=%0d data=%0h expected filt=%0b row=%0d data=%0h",
                   filt_wr_en, wr_row, wr_data, we.filt, we.row, we.data);
        end
      end
    end
    if (conv_start) begin
      n_cmp++;
      n_launch++;
      if (ln_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_launch: got conv_start ts=%0b expected none (cycle %0d)",
                 conv_timestep, cyc);
      end else begin
        le = ln_q.pop_front();
        if (le.ts !== conv_timestep || le.cyc != cyc) begin
          n_bad++;
          $display("FAIL launch: got ts=%0b cycle=%0d expected ts=%0b cycle=%0d",
                   conv_timestep, cyc, le.ts, le.cyc);
        end
      end
    end
  end

  task automatic add(input logic f, input logic [2:0] r, input logic ts,
                     input logic [DW-1:0] d, input logic wr, input logic launch);
    vecs.push_back('{f, r, ts, d, wr, launch});
  endtask

  // Called #1 after a rising edge; returns #1 after the transfer edge.
  task automatic send(input vec_t v);
    bit ok;
    in_valid = 1'b1;
    in_ifmapb_filter = v.filt;
    in_filter_row = v.row;
    in_timestep = v.ts;
    in_data = v.data;
    if (v.wr) wr_q.push_back('{v.filt, v.row, v.data});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected 1 (row %0d)", v.row);
      if (v.wr) void'(wr_q.pop_back());
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    if (v.launch) ln_q.push_back('{v.ts, cyc + 1});
    in_valid = 1'b0;
  endtask

  task automatic run(input int first, input int last);
    for (int i = first; i < last; i++) send(vecs[i]);
  endtask

  task automatic wait_launch(input int target);
    for (int i = 0; i < 50 && n_launch < target; i++) @(negedge clk);
    chk("launch_seen", 64'(n_launch), 64'(target));
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    conv_done = 1'b1;
    @(posedge clk); #1;
    conv_done = 1'b0;
  endtask

  initial begin
    int stalls;

    for (int r = 0; r < 5; r++) add(1'b1, 3'(r), 1'b0, 40'h0A0B0C0D0E + 40'(r), 1'b1, 1'b0);
    add(1'b0, 3'd4, 1'b1, 40'h5500000004, 1'b1, 1'b0);
    add(1'b0, 3'd2, 1'b1, 40'h5500000002, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 40'h5500000000, 1'b1, 1'b0);
    add(1'b0, 3'd1, 1'b1, 40'h5500000001, 1'b1, 1'b0);
    add(1'b0, 3'd3, 1'b1, 40'h5500000003, 1'b1, 1'b1);
    add(1'b0, 3'd1, 1'b0, 40'h6600000001, 1'b1, 1'b0);
    add(1'b0, 3'd2, 1'b1, 40'h66000000EE, 1'b0, 1'b0);
    add(1'b0, 3'd2, 1'b0, 40'h6600000002, 1'b1, 1'b0);
    add(1'b0, 3'd3, 1'b0, 40'h6600000003, 1'b1, 1'b0);
    add(1'b0, 3'd4, 1'b0, 40'h6600000004, 1'b1, 1'b1);
    add(1'b1, 3'd6, 1'b0, 40'hBAD0000006, 1'b0, 1'b0);
    add(1'b0, 3'd1, 1'b1, 40'h7700000001, 1'b1, 1'b0);
    add(1'b0, 3'd1, 1'b1, 40'h7711111111, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 40'h7700000000, 1'b1, 1'b0);
    add(1'b0, 3'd2, 1'b1, 40'h7700000002, 1'b1, 1'b0);
    add(1'b0, 3'd3, 1'b1, 40'h7700000003, 1'b1, 1'b0);
    add(1'b0, 3'd4, 1'b1, 40'h7700000004, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_conv_count", 64'(conv_count), 64'd0);
    chk("rst_filter_loaded", 64'(filter_loaded), 64'd0);
    chk("rst_err", 64'({err_row, err_ts}), 64'd0);
    chk("rst_conv_timestep", 64'(conv_timestep), 64'd0);

    // Ifmap before any filter must stall, not drop.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ifmapb_filter = 1'b0;
    in_filter_row = 3'd0;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) stalls++;
    end
    chk("ifmap_stall_ready", 64'(stalls), 64'd0);
    chk("stall_conv_count", 64'(conv_count), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    run(0, 5);
    @(negedge clk);
    chk("filter_loaded", 64'(filter_loaded), 64'd1);
    @(posedge clk); #1;
    run(5, 10);
    wait_launch(1);

    // BUSY hold: packet waits until conv_done, then goes on the following edge.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ifmapb_filter = 1'b0;
    in_filter_row = 3'd0;
    in_timestep = 1'b0;
    in_data = 40'h6600000000;
    wr_q.push_back('{1'b0, 3'd0, 40'h6600000000});
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready) stalls++;
    end
    chk("busy_ready", 64'(stalls), 64'd0);
    @(posedge clk); #1;
    conv_done = 1'b1;
    @(negedge clk);
    chk("busy_ready_at_done", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    conv_done = 1'b0;
    @(negedge clk);
    chk("ready_after_done", 64'(in_ready), 64'd1);
    chk("conv_count_1", 64'(conv_count), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    run(10, 12);
    @(negedge clk);
    chk("err_ts_set", 64'(err_ts), 64'd1);
    chk("err_row_clear", 64'(err_row), 64'd0);
    @(posedge clk); #1;
    run(12, 15);
    wait_launch(2);
    repeat (2) @(posedge clk);
    pulse_done();
    @(negedge clk);
    chk("conv_count_2", 64'(conv_count), 64'd2);

    @(posedge clk); #1;
    run(15, 21);
    @(negedge clk);
    chk("err_row_set", 64'(err_row), 64'd1);
    chk("no_premature_launch", 64'(n_launch), 64'd2);
    @(posedge clk); #1;
    run(21, 22);
    wait_launch(3);

    // Reset while BUSY abandons everything; a late conv_done is ignored.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_ifmapb_filter = 1'b0;
    in_filter_row = 3'd0;
    pulse_done();
    @(negedge clk);
    chk("post_rst_conv_count", 64'(conv_count), 64'd0);
    chk("post_rst_filter_loaded", 64'(filter_loaded), 64'd0);
    chk("post_rst_err", 64'({err_row, err_ts}), 64'd0);
    chk("post_rst_conv_timestep", 64'(conv_timestep), 64'd0);
    chk("post_rst_strobes", 64'({filt_wr_en, ifm_wr_en, conv_start}), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("launch_total", 64'(n_launch), 64'd3);
    chk("writes_pending", 64'(wr_q.size()), 64'd0);
    chk("launches_pending", 64'(ln_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_load_scheduler.md
# pe_load_scheduler

Clocked sequencer that sits between the PE depacketizer and the PE convolution datapath. It accepts depacketized fields one packet at a time over a valid/ready handshake, routes filter rows and ifmap rows into their row buffers, and tracks which rows have arrived. Once a full filter and a full ifmap window for one timestep are present, it launches exactly one convolution and waits for the datapath to finish before accepting further ifmap rows.

## Interface
- FILTER_WIDTH, 8, width of one filter/ifmap element; one row carries 5*FILTER_WIDTH bits.
- NUM_ROWS, 5, rows per filter/ifmap window; valid row indices are 0..NUM_ROWS-1, and NUM_ROWS must be ≤ 8.
- CNT_W, 16, width of conv_count.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  depacketized packet present.
- in_ready  output  1  block can take the packet.
- in_ifmapb_filter  input  1  0 = ifmap row, 1 = filter row.
- in_filter_row  input  3  row index.
- in_timestep  input  1  packet timestep bit.
- in_data  input  5*FILTER_WIDTH  row payload.
- filt_wr_en  output  1  one-cycle filter row-buffer write strobe.
- ifm_wr_en  output  1  one-cycle ifmap row-buffer write strobe.
- wr_row  output  3  row index for the active strobe.
- wr_data  output  5*FILTER_WIDTH  row payload for the active strobe.
- conv_start  output  1  one-cycle convolution launch pulse.
- conv_timestep  output  1  timestep of the launched window.
- conv_done  input  1  datapath finished (single-cycle pulse).
- filter_loaded  output  1  all NUM_ROWS filter rows present.
- conv_count  output  CNT_W  number of completed convolutions.
- err_row  output  1  sticky: a packet arrived with row ≥ NUM_ROWS.
- err_ts  output  1  sticky: an ifmap row's timestep differs from the window's timestep.

## Operation
- States:
  - LOAD: accept packets.
  - START: issue the launch.
  - BUSY: wait for the datapath.
- Internal state:
  - filt_mask[NUM_ROWS-1:0] and ifm_mask[NUM_ROWS-1:0]: row-present bits.
  - win_ts: timestep of the current ifmap window.
- Transfer rule: a transfer occurs on a rising edge with in_valid & in_ready.
- in_ready:
  - Driven combinationally.
  - 1 in LOAD when the packet is a filter row, or when the packet is an ifmap row and filter_loaded=1.
  - 0 for ifmap rows while filter_loaded=0 (they stall and are not dropped).
  - 0 in START and BUSY.
  - 0 while rst is asserted.
- Filter transfer:
  - Sets filt_mask[row] and pulses filt_wr_en.
  - A duplicate row overwrites the buffer; the mask is unchanged.
  - Filter reload is allowed in LOAD even while ifmap rows are partially collected.
- filter_loaded = &filt_mask. It never clears except on reset.
- Ifmap transfer:
  - If ifm_mask is all zero, latch win_ts from the packet.
  - If ifm_mask is nonzero and in_timestep ≠ win_ts: consume the packet, produce no write, leave the mask unchanged, and set err_ts.
  - Otherwise set ifm_mask[row] and pulse ifm_wr_en; a duplicate row overwrites the buffer.
- Row ≥ NUM_ROWS (either packet type): the packet is consumed, no strobe is issued, masks are unchanged, and err_row is set.
- LOAD→START on the edge where the transfer completes ifm_mask.
- START:
  - conv_start=1 for exactly one cycle, with conv_timestep=win_ts.
  - Next state is BUSY.
- BUSY→LOAD on the edge where conv_done=1. On that edge: clear ifm_mask and increment conv_count (wraps modulo 2^CNT_W).
- conv_done in LOAD or START is ignored.
- A filter transfer never triggers START; only ifmap completion does.

## Timing
- Reset (asynchronous, immediate): state=LOAD; all masks, win_ts, conv_count, err_row and err_ts = 0.
- Reset output values: all strobes 0, conv_timestep=0, filter_loaded=0.
- Reset mid-operation (including in BUSY) abandons the window and filter. A later conv_done is ignored.
- Write strobes:
  - Registered; high during the cycle after the transfer edge.
  - wr_row and wr_data are valid only while a strobe is high.
  - At most one of filt_wr_en or ifm_wr_en is high per cycle.
- Launch sequence: last ifmap transfer at edge N → ifm_wr_en high in cycle N..N+1 and state=START → conv_start high in cycle N+1..N+2 → BUSY from edge N+2.
- Launch latency: the write lands one edge before conv_start is sampled.
- Back-to-back transfers are sustainable at one per cycle in LOAD.
- Minimum turnaround: conv_done at edge M gives in_ready=1 from edge M onward for the next ifmap row.

## Test plan
- Reset, then ifmap row 0 presented with in_valid=1 → in_ready=0 indefinitely; no strobes; conv_count=0.
- Filter rows 0..4 (data 0x0A0B0C0D0E+row), then ifmap rows 4,2,0,1,3 with ts=1 → five filt_wr_en and five ifm_wr_en pulses with matching wr_row/wr_data; exactly one conv_start with conv_timestep=1, two cycles after the last transfer.
- While in BUSY, hold an ifmap packet valid → in_ready=0. Pulse conv_done → packet accepted on the next edge; conv_count=1.
- Ifmap rows 0,1 with ts=0, then row 2 with ts=1 → row 2 consumed with no ifm_wr_en, err_ts=1. Rows 2..4 with ts=0 → launch with conv_timestep=0.
- Filter row 6 → consumed, no strobe, err_row=1. Duplicate ifmap row 1 → second write issued; no premature launch.
- Assert rst during BUSY, deassert, then pulse conv_done → no count change, filter_loaded=0, all outputs at reset values.
